// File: rtl/basic_instr_sequencer.sv
// Program sequencer for the 8-register basic processor.
// Issues instruction/load pairs from a small program and captures OUT.
module basic_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PWR_EN,
  input  logic [AW-1:0] PWR_ADDR,
  input  logic [16:0]   PWR_DATA,
  input  logic          START,
  input  logic          STEP_MODE,
  input  logic          STEP,
  output logic [7:0]    INSTR,
  output logic [7:0]    Load,
  input  logic [7:0]    PROC_OUT,
  output logic [7:0]    RES_DATA,
  output logic          RES_VALID,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] PC,
  output logic [AW:0]   COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam logic [7:0] NOP = 8'h40;

  state_t      state;
  state_t      state_nx;
  logic [16:0] mem [DEPTH];
  logic [16:0] ent;
  logic        step_f;
  logic        issue;
  logic        last;

  assign ent  = mem[PC];
  assign last = (PC == AW'(DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (START) state_nx = RUN;
      RUN: begin
        if (ent[16] || last) state_nx = IDLE;
        else if (step_f)     state_nx = PAUSE;
        else                 state_nx = RUN;
      end
      PAUSE: if (STEP) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // outputs depend only on registered state/PC so they hold all cycle
  always_comb begin
    issue = (state == RUN) && !ent[16];
    INSTR = NOP;
    Load  = 8'h00;
    BUSY  = (state != IDLE);
    if (issue) begin
      INSTR = ent[7:0];
      Load  = ent[15:8];
    end
  end

  // program memory survives reset
  always_ff @(posedge CLK) begin
    if (PWR_EN && state == IDLE) mem[PWR_ADDR] <= PWR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC        <= '0;
      COUNT     <= '0;
      step_f    <= 1'b0;
      RES_DATA  <= 8'h00;
      RES_VALID <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE      <= (state == RUN) && (state_nx == IDLE);
      RES_VALID <= issue && (ent[7:6] == 2'b11);
      if (issue && ent[7:6] == 2'b11) RES_DATA <= PROC_OUT;
      if (state == IDLE && START) begin
        PC     <= '0;
        COUNT  <= '0;
        step_f <= STEP_MODE;
      end
      if (issue) begin
        COUNT <= COUNT + 1'b1;
        if (!last) PC <= PC + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_basic_instr_sequencer.sv
// Bench for basic_instr_sequencer with a small processor model.
// Directed tables plus hand-written multi-cycle sequences.
module tb_basic_instr_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        PWR_EN;
  logic [3:0]  PWR_ADDR;
  logic [16:0] PWR_DATA;
  logic        START;
  logic        STEP_MODE;
  logic        STEP;
  logic [7:0]  INSTR;
  logic [7:0]  Load;
  logic [7:0]  PROC_OUT;
  logic [7:0]  RES_DATA;
  logic        RES_VALID;
  logic        BUSY;
  logic        DONE;
  logic [3:0]  PC;
  logic [4:0]  COUNT;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] load;
    logic       busy;
    logic       done;
    logic       rv;
    logic [7:0] rd;
  } exp_t;

  exp_t p1[7];
  exp_t p2[7];
  exp_t cur[7];

  logic [7:0] r [8];

  basic_instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .CLK(clk), .RST(RST),
    .PWR_EN(PWR_EN), .PWR_ADDR(PWR_ADDR),
    .PWR_DATA(PWR_DATA),
    .START(START), .STEP_MODE(STEP_MODE),
    .STEP(STEP),
    .INSTR(INSTR), .Load(Load),
    .PROC_OUT(PROC_OUT),
    .RES_DATA(RES_DATA), .RES_VALID(RES_VALID),
    .BUSY(BUSY), .DONE(DONE),
    .PC(PC), .COUNT(COUNT)
  );

  always #5 clk = ~clk;

  // processor: [7:6] op, [5:3] dst, [2:0] src; acts on falling edge
  initial begin
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    PROC_OUT = 8'h00;
  end

  always @(negedge clk) begin
    case (INSTR[7:6])
      2'b00: r[INSTR[5:3]] = Load;
      2'b01: r[INSTR[5:3]] = r[INSTR[2:0]];
      2'b10: r[INSTR[5:3]] = r[0] + r[INSTR[2:0]];
      default: PROC_OUT = r[INSTR[5:3]];
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic prog(logic [3:0] a, logic [16:0] d);
    PWR_EN = 1'b1;
    PWR_ADDR = a;
    PWR_DATA = d;
    tick();
    PWR_EN = 1'b0;
  endtask

  task automatic load_p1();
    prog(4'd0, 17'h00500);
    prog(4'd1, 17'h00308);
    prog(4'd2, 17'h00091);
    prog(4'd3, 17'h000D0);
    prog(4'd4, 17'h10000);
  endtask

  task automatic run_table(string nm, bit wr, logic [16:0] wd);
    START = 1'b1;
    if (wr) begin
      PWR_EN = 1'b1;
      PWR_ADDR = 4'd0;
      PWR_DATA = wd;
    end
    tick();
    START = 1'b0;
    PWR_EN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s[%0d].instr", nm, i), 32'(INSTR), 32'(cur[i].instr));
      chk($sformatf("%s[%0d].load", nm, i), 32'(Load), 32'(cur[i].load));
      chk($sformatf("%s[%0d].busy", nm, i), 32'(BUSY), 32'(cur[i].busy));
      chk($sformatf("%s[%0d].done", nm, i), 32'(DONE), 32'(cur[i].done));
      chk($sformatf("%s[%0d].rv", nm, i), 32'(RES_VALID), 32'(cur[i].rv));
      if (cur[i].rv)
        chk($sformatf("%s[%0d].rd", nm, i), 32'(RES_DATA), 32'(cur[i].rd));
      tick();
    end
  endtask

  task automatic wait_done(string nm, int lim, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      if (DONE) seen = 1'b1;
      else begin
        n++;
        tick();
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin : main
    logic [7:0] sx [4];
    int n;
    sx = '{8'h08, 8'h91, 8'hD0, 8'h40};

    p1[0] = '{8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00};
    p1[1] = '{8'h08, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00};
    p1[2] = '{8'h91, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    p1[3] = '{8'hD0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    p1[4] = '{8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08};
    p1[5] = '{8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    p1[6] = '{8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    p2[0] = '{8'h10, 8'h08, 1'b1, 1'b0, 1'b0, 8'h00};
    p2[1] = '{8'h18, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
    p2[2] = '{8'hD0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    p2[3] = '{8'hD8, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08};
    p2[4] = '{8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    p2[5] = '{8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    p2[6] = '{8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    RST = 1'b1;
    PWR_EN = 1'b0;
    PWR_ADDR = 4'd0;
    PWR_DATA = 17'h0;
    START = 1'b0;
    STEP_MODE = 1'b0;
    STEP = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_instr", 32'(INSTR), 32'h40);
    chk("rst_load", 32'(Load), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_rv", 32'(RES_VALID), 32'd0);
    chk("rst_rd", 32'(RES_DATA), 32'h00);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);

    // free run
    load_p1();
    cur = p1;
    run_table("free", 1'b0, 17'h0);
    chk("free_count", 32'(COUNT), 32'd4);
    chk("free_pc", 32'(PC), 32'd4);

    // full program without HALT stops at the last address
    for (int a = 0; a < 16; a++) prog(4'(a), 17'h00040);
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done("wrap", 40, n);
    chk("wrap_cycles", 32'(n), 32'd16);
    chk("wrap_count", 32'(COUNT), 32'd16);
    chk("wrap_pc", 32'(PC), 32'd15);
    chk("wrap_busy", 32'(BUSY), 32'd0);

    // single step; STEP during RUN and START during PAUSE ignored
    load_p1();
    START = 1'b1;
    STEP_MODE = 1'b1;
    STEP = 1'b1;
    tick();
    START = 1'b0;
    STEP_MODE = 1'b0;
    chk("step0_instr", 32'(INSTR), 32'h00);
    tick();
    STEP = 1'b0;
    chk("step0_pause", 32'(INSTR), 32'h40);
    chk("step0_busy", 32'(BUSY), 32'd1);
    chk("step0_pc", 32'(PC), 32'd1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("step_start_ign", 32'(INSTR), 32'h40);
    chk("step_start_pc", 32'(PC), 32'd1);
    for (int k = 0; k < 4; k++) begin
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      chk($sformatf("step%0d_instr", k + 1), 32'(INSTR), 32'(sx[k]));
      chk($sformatf("step%0d_busy", k + 1), 32'(BUSY), 32'd1);
      tick();
      if (k < 3) begin
        chk($sformatf("step%0d_nop", k + 1), 32'(INSTR), 32'h40);
        chk($sformatf("step%0d_hold", k + 1), 32'(BUSY), 32'd1);
      end
      if (k == 2) begin
        chk("step_rv", 32'(RES_VALID), 32'd1);
        chk("step_rd", 32'(RES_DATA), 32'h08);
      end
      if (k == 3) begin
        chk("step_done", 32'(DONE), 32'd1);
        chk("step_busy_end", 32'(BUSY), 32'd0);
      end
    end
    chk("step_count", 32'(COUNT), 32'd4);

    // writes and START while busy are dropped
    START = 1'b1;
    tick();
    START = 1'b0;
    PWR_EN = 1'b1;
    PWR_ADDR = 4'd0;
    PWR_DATA = 17'h0FFC0;
    tick();
    PWR_EN = 1'b0;
    START = 1'b1;
    chk("busy_wr_i1", 32'(INSTR), 32'h08);
    tick();
    START = 1'b0;
    chk("busy_start_i2", 32'(INSTR), 32'h91);
    chk("busy_start_pc", 32'(PC), 32'd2);
    wait_done("busy", 20, n);
    tick();
    run_table("rerun", 1'b0, 17'h0);

    // reset mid-run
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst_instr", 32'(INSTR), 32'h40);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_rd", 32'(RES_DATA), 32'h00);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mrst_done%0d", i), 32'(DONE), 32'd0);
      chk($sformatf("mrst_rv%0d", i), 32'(RES_VALID), 32'd0);
      tick();
    end
    run_table("after_rst", 1'b0, 17'h0);

    // back-to-back outputs; entry 0 written on the START edge
    prog(4'd1, 17'h05A18);
    prog(4'd2, 17'h000D0);
    prog(4'd3, 17'h000D8);
    prog(4'd4, 17'h10000);
    cur = p2;
    run_table("b2b", 1'b1, 17'h00810);
    chk("b2b_count", 32'(COUNT), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/basic_instr_sequencer.md
# basic_instr_sequencer

Program sequencer for the 8-register basic processor. It holds a small program of instruction/load-data pairs, issues them one per clock on the processor's INSTR and Load inputs, and captures the processor's OUT bus whenever an output-class instruction is issued. It sits between the test or host side and the processor core, and is the instruction source that feeds that datapath.

## Interface
- DEPTH, 16, number of program entries
- AW, 4, program address width (2^AW = DEPTH)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high; clears control state only (program memory retained); does not drive the processor's reset
- PWR_EN  in  1  program write strobe
- PWR_ADDR  in  AW  program write address
- PWR_DATA  in  17  entry: [16]=HALT, [15:8]=load data, [7:0]=instruction
- START  in  1  run request, 1-cycle pulse
- STEP_MODE  in  1  single-step select, sampled when START is accepted
- STEP  in  1  advance one instruction in step mode
- INSTR  out  8  to processor INSTR
- Load  out  8  to processor Load
- PROC_OUT  in  8  from processor OUT
- RES_DATA  out  8  last captured processor output
- RES_VALID  out  1  1-cycle pulse, RES_DATA newly updated
- BUSY  out  1  high in RUN or PAUSE
- DONE  out  1  1-cycle pulse, run finished
- PC  out  AW  current program address
- COUNT  out  AW+1  instructions issued in current or last run

## Operation
- Memory: DEPTH x 17 register array, combinational read at PC. Written on PWR_EN only in IDLE; writes while BUSY are dropped.
- FSM states: IDLE, RUN, PAUSE.
- IDLE: START -> RUN, PC<=0, COUNT<=0, step flag<=STEP_MODE. START while BUSY is ignored.
- RUN, entry mem[PC]:
  - HALT=1: the entry is not issued; the NOP is driven. Next state IDLE, DONE next cycle.
  - HALT=0: INSTR=mem[PC][7:0] and Load=mem[PC][15:8] for the whole cycle. COUNT+1.
    - If PC==DEPTH-1: next state IDLE, DONE next cycle, PC holds.
    - Otherwise PC+1, and next state is PAUSE if the step flag is set, else RUN.
- PAUSE: the NOP is driven. STEP -> RUN next cycle. START is ignored.
- NOP: whenever no entry is issued, INSTR=8'h40 (MOVE A->A) and Load=8'h00.
- Capture:
  - If the issued INSTR[7:6]==2'b11, RES_DATA<=PROC_OUT at the rising edge ending the issue cycle. The processor updates OUT on the intervening falling edge.
  - RES_VALID is high for the following cycle.
  - Back-to-back output instructions give back-to-back RES_VALID pulses.
- Simultaneous START and PWR_EN in IDLE: the write and the start both take effect at the same edge. The first RUN cycle reads the updated memory.

## Timing
- Reset values:
  - state IDLE, PC=0, COUNT=0, step flag=0
  - INSTR=8'h40, Load=8'h00
  - RES_DATA=8'h00, RES_VALID=0, BUSY=0, DONE=0
- INSTR and Load are decoded from registered state/PC only and are stable from just after the rising edge through the whole cycle.
- Latency: START at edge k; entry 0 issued in cycle k+1; entry n issued in cycle k+1+n (free-run).
- DONE: asserted in the cycle after the last RUN cycle. BUSY drops in that same cycle.
- RST mid-run: IDLE next cycle, NOP driven, no DONE, pending RES_VALID suppressed, RES_DATA cleared.
- STEP in RUN or IDLE is ignored. STEP asserted in the same cycle PAUSE is entered is ignored.

## Test plan
- Program {0:I=00 L=05, 1:I=08 L=03, 2:I=91, 3:I=D0, 4:HALT}, START with free-run, processor attached:
  - INSTR sequence 00,08,91,D0,40 on cycles k+1..k+5
  - RES_VALID once with RES_DATA=8'h08
  - COUNT=4; DONE at k+6
- All 16 entries non-HALT with I=40: PC wraps to no further address, DONE after the 16th issue, COUNT=16, PC=15.
- Same program as the first test with STEP_MODE=1:
  - one instruction per STEP pulse, NOP between pulses
  - BUSY held throughout; identical RES_DATA=8'h08
- PWR_EN to address 0 while BUSY: memory is unchanged, and a rerun gives an identical trace. START during RUN: no restart, PC continues.
- RST asserted on cycle k+2 of a run: IDLE, INSTR=40, BUSY=0, no DONE or RES_VALID. Program is intact, and a new START reproduces the full trace.
- Two consecutive output instructions D0, D8 (regs C=08, D=xx): RES_VALID on two consecutive cycles with the respective values.
